// File: rtl/uart_matrix_input_if.sv
// uart_matrix_input_if: session handshake and storage write bus between the
// session FSM (master) and the UART matrix input block (slave).
interface uart_matrix_input_if;
    logic        w_start_in;
    logic        w_in_done;
    logic        w_in_busy;
    logic        w_in_err;
    logic        w_wr_en;
    logic [7:0]  w_wr_addr;
    logic [31:0] w_wr_data;
    logic [7:0]  w_elem_count;

    modport master (
        output w_start_in,
        input  w_in_done, w_in_busy, w_in_err,
        input  w_wr_en, w_wr_addr, w_wr_data, w_elem_count
    );

    modport slave (
        input  w_start_in,
        output w_in_done, w_in_busy, w_in_err,
        output w_wr_en, w_wr_addr, w_wr_data, w_elem_count
    );
endinterface

// File: rtl/uart_matrix_input.sv
// uart_matrix_input: 8N1 UART receiver feeding an ASCII decimal token parser.
// Each delimited number is written to element storage as one 32-bit word.
// Optional feature macro RANGE_CHECK_EN: values above MAX_VAL are rejected
// (error flag set, no write) instead of being stored.
module uart_matrix_input #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115200,
    parameter int MAX_ELEMS = 25,
    parameter int MAX_VAL   = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               uart_rx_pin,
    uart_matrix_input_if.slave bus
);

    localparam int BIT_CYC = CLK_FREQ / BAUD_RATE;
    localparam int CW      = $clog2(BIT_CYC + 1);
    localparam logic [CW-1:0] FULL_LAST  = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(BIT_CYC / 2 - 1);
    localparam logic [7:0]    MAX_ELEMS_W = 8'(MAX_ELEMS);
`ifdef RANGE_CHECK_EN
    localparam logic [15:0]   MAX_VAL_W   = 16'(MAX_VAL);
`endif

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE} state_e;

    // ---------------- receiver ----------------
    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e       rx_state_q, rx_state_d;
    logic [CW-1:0]   cyc_q, cyc_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            byte_vld_q, byte_vld_d;
    logic            frame_err_q, frame_err_d;

    // Two-flop synchroniser plus previous-sample register for edge detection;
    // all reset high so a reset never looks like a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx_pin;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // Receiver state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q  <= RX_IDLE;
            cyc_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            byte_vld_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_state_q  <= rx_state_d;
            cyc_q       <= cyc_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            byte_vld_q  <= byte_vld_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Receiver next state: mid-bit sampling, glitch reject on the start bit.
    always_comb begin
        rx_state_d  = rx_state_q;
        cyc_d       = cyc_q + 1'b1;
        bit_d       = bit_q;
        shift_d     = shift_q;
        byte_vld_d  = 1'b0;
        frame_err_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                cyc_d = '0;
                if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
            end
            RX_START: begin
                if (cyc_q == HALF_LAST) begin
                    cyc_d = '0;
                    bit_d = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cyc_q == FULL_LAST) begin
                    cyc_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cyc_q == FULL_LAST) begin
                    cyc_d       = '0;
                    rx_state_d  = RX_IDLE;
                    byte_vld_d  = rx_sync_q;
                    frame_err_d = !rx_sync_q;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // ---------------- parser ----------------
    state_e      state_q, state_d;
    logic [15:0] acc_q, acc_d;
    logic        seen_q, seen_d;
    logic        eol_q, eol_d;
    logic        discard_q, discard_d;
    logic [7:0]  count_q, count_d;
    logic        err_q, err_d;
    logic        wr_en_q, wr_en_d;
    logic [7:0]  wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;

    logic        is_digit;
    logic [19:0] acc_ext;

    assign is_digit = (shift_q >= 8'h30) && (shift_q <= 8'h39);
    assign acc_ext  = 20'(acc_q) * 20'd10 + 20'(shift_q[3:0]);

    // Parser state register; write strobe is registered to give the
    // two-clock delimiter-to-write latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            seen_q    <= 1'b0;
            eol_q     <= 1'b0;
            discard_q <= 1'b0;
            count_q   <= '0;
            err_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            seen_q    <= seen_d;
            eol_q     <= eol_d;
            discard_q <= discard_d;
            count_q   <= count_d;
            err_q     <= err_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Parser next state: tokenise digits, write on delimiters, stop on LF/cap.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        seen_d    = seen_q;
        eol_d     = eol_q;
        discard_d = discard_q;
        count_d   = count_q;
        err_d     = err_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        // A framing error flags the running session; the byte itself is lost.
        if (frame_err_q && state_q != S_IDLE) err_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (bus.w_start_in) begin
                    acc_d     = '0;
                    seen_d    = 1'b0;
                    eol_d     = 1'b0;
                    discard_d = 1'b0;
                    count_d   = '0;
                    err_d     = 1'b0;
                    state_d   = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (byte_vld_q) begin
                    if (is_digit) begin
                        // Digits after an illegal character belong to the
                        // discarded token and are skipped up to the delimiter.
                        if (!discard_q) begin
                            acc_d  = (acc_ext > 20'h0FFFF) ? 16'hFFFF : acc_ext[15:0];
                            seen_d = 1'b1;
                        end
                    end else if (shift_q == 8'h20 || shift_q == 8'h0D) begin
                        discard_d = 1'b0;
                        if (seen_q) state_d = S_WRITE;
                    end else if (shift_q == 8'h0A) begin
                        discard_d = 1'b0;
                        if (seen_q) begin
                            eol_d   = 1'b1;
                            state_d = S_WRITE;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        err_d     = 1'b1;
                        acc_d     = '0;
                        seen_d    = 1'b0;
                        discard_d = 1'b1;
                    end
                end
            end
            S_WRITE: begin
`ifdef RANGE_CHECK_EN
                if (acc_q > MAX_VAL_W) begin
                    err_d = 1'b1;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = count_q;
                    wr_data_d = {16'h0, acc_q};
                    count_d   = count_q + 8'd1;
                end
`else
                wr_en_d   = 1'b1;
                wr_addr_d = count_q;
                wr_data_d = {16'h0, acc_q};
                count_d   = count_q + 8'd1;
`endif
                acc_d  = '0;
                seen_d = 1'b0;
                if (eol_q || (count_q + 8'd1) == MAX_ELEMS_W) state_d = S_DONE;
                else                                          state_d = S_COLLECT;
            end
            S_DONE: begin
                if (!bus.w_start_in) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.w_in_done    = (state_q == S_DONE);
    assign bus.w_in_busy    = (state_q != S_IDLE);
    assign bus.w_in_err     = err_q;
    assign bus.w_wr_en      = wr_en_q;
    assign bus.w_wr_addr    = wr_addr_q;
    assign bus.w_wr_data    = wr_data_q;
    assign bus.w_elem_count = count_q;

endmodule

// File: tb/tb_uart_matrix_input.sv
// tb_uart_matrix_input: drives ASCII sessions over the serial line and checks
// storage writes against a scoreboard queue of expected (addr, data) pairs.
module tb_uart_matrix_input;

    localparam int CLK_FREQ  = 1_600_000;
    localparam int BAUD_RATE = 100_000;
    localparam int BIT_CYC   = CLK_FREQ / BAUD_RATE;
    localparam int MAX_ELEMS = 3;
    localparam int MAX_VAL   = 9;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx    = 1'b1;

    uart_matrix_input_if bus ();

    uart_matrix_input #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD_RATE(BAUD_RATE),
        .MAX_ELEMS(MAX_ELEMS),
        .MAX_VAL  (MAX_VAL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_rx_pin(rx),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [39:0] exp_q[$];
    logic [39:0] mon_e;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: every write strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bus.w_wr_en === 1'b1) begin
            $display("write addr=%0d data=%0h", bus.w_wr_addr, bus.w_wr_data);
            if (exp_q.size() == 0) begin
                chk("unexpected_wr", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", {24'h0, bus.w_wr_addr}, {24'h0, mon_e[39:32]});
                chk("wr_data", bus.w_wr_data, mon_e[31:0]);
            end
        end
    end

    task automatic expect_wr(input logic [7:0] addr, input logic [31:0] data);
        exp_q.push_back({addr, data});
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (BIT_CYC) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT_CYC) @(negedge clk);
        end
        rx = stop;
        repeat (BIT_CYC) @(negedge clk);
        rx = 1'b1;
        repeat (BIT_CYC) @(negedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    endtask

    task automatic start_session(input string name);
        $display("session %s", name);
        @(negedge clk);
        bus.w_start_in = 1'b1;
        repeat (2) @(negedge clk);
        chk("busy_on_start", {31'h0, bus.w_in_busy}, 32'd1);
    endtask

    task automatic end_session(input int exp_count, input logic exp_err);
        int budget;
        budget = 400;
        while (bus.w_in_done !== 1'b1 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk("done", {31'h0, bus.w_in_done}, 32'd1);
        chk("elem_count", {24'h0, bus.w_elem_count}, 32'(exp_count));
        chk("err", {31'h0, bus.w_in_err}, {31'h0, exp_err});
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        repeat (40) @(negedge clk);
        chk("done_held", {31'h0, bus.w_in_done}, 32'd1);
        bus.w_start_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("done_clear", {31'h0, bus.w_in_done}, 32'd0);
        chk("busy_clear", {31'h0, bus.w_in_busy}, 32'd0);
        exp_q.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        logic [31:0] packed_ctl;
        packed_ctl = {28'h0, bus.w_in_done, bus.w_in_busy, bus.w_in_err, bus.w_wr_en};
        chk({tag, "_ctl"}, packed_ctl, 32'd0);
        chk({tag, "_addr_cnt"}, {16'h0, bus.w_wr_addr, bus.w_elem_count}, 32'd0);
        chk({tag, "_data"}, bus.w_wr_data, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.w_start_in = 1'b0;
        repeat (5) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk_reset_outputs("post_reset");

        // Basic three-element line; third write also reaches the element cap.
        start_session("basic");
        expect_wr(8'd0, 32'd3);
        expect_wr(8'd1, 32'd12);
        expect_wr(8'd2, 32'd7);
        send_str("3 12 7\n");
        end_session(3, 1'b0);

        // Framing error on a digit: flagged, byte not accumulated.
        start_session("frame_err");
        expect_wr(8'd0, 32'd5);
        send_str("5");
        send_byte(8'h37, 1'b0);
        send_str(" \n");
        end_session(1, 1'b1);

        // Illegal character discards the rest of its token.
        start_session("bad_char");
        expect_wr(8'd0, 32'd4);
        expect_wr(8'd1, 32'd6);
        send_str("4 x9 6\n");
        end_session(2, 1'b1);

        // Element cap: fourth value arrives in S_DONE and is dropped.
        start_session("cap");
        expect_wr(8'd0, 32'd1);
        expect_wr(8'd1, 32'd2);
        expect_wr(8'd2, 32'd3);
        send_str("1 2 3 4\n");
        end_session(3, 1'b0);

        // Leading space ignored, saturation, CR delimiter, bare LF ends session.
        start_session("saturate");
`ifdef RANGE_CHECK_EN
        send_str(" 70000");
        send_byte(8'h0D, 1'b1);
        send_str("\n");
        end_session(0, 1'b1);
`else
        expect_wr(8'd0, 32'h0000_FFFF);
        send_str(" 70000");
        send_byte(8'h0D, 1'b1);
        send_str("\n");
        end_session(1, 1'b0);
`endif

        // Multi-digit value above MAX_VAL.
        start_session("range");
`ifdef RANGE_CHECK_EN
        expect_wr(8'd0, 32'd7);
        expect_wr(8'd1, 32'd2);
        send_str("7 15 2\n");
        end_session(2, 1'b1);
`else
        expect_wr(8'd0, 32'd7);
        expect_wr(8'd1, 32'd15);
        expect_wr(8'd2, 32'd2);
        send_str("7 15 2\n");
        end_session(3, 1'b0);
`endif

        // Reset in the middle of the second digit's frame.
        start_session("reset_mid");
        expect_wr(8'd0, 32'd8);
        send_str("8 ");
        rx = 1'b0;
        repeat (BIT_CYC) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = (i == 0 || i == 3) ? 1'b1 : 1'b0;
            repeat (BIT_CYC) @(negedge clk);
        end
        rst_n = 1'b0;
        bus.w_start_in = 1'b0;
        rx = 1'b1;
        repeat (5) @(negedge clk);
        chk_reset_outputs("in_reset");
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset_release");
        chk("sb_after_reset", 32'(exp_q.size()), 32'd0);
        repeat (3 * BIT_CYC) @(negedge clk);
        chk("no_wr_after_reset", {31'h0, bus.w_wr_en}, 32'd0);

        start_session("after_reset");
        expect_wr(8'd0, 32'd6);
        send_str("6\n");
        end_session(1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
